rle_encoder: RTL

Run-length encoder stage directly downstream of the 8-point DCT in System2 (DCT+RLE). Each cycle that a DCT block is handed over, it captures all eight signed 19-bit coefficients Z0..Z7 in parallel. It then scans them in index order and emits a serial stream of (run, value) tokens over a valid/ready handshake. The token stream is the compressed EEG representation consumed by the packing/output stage.

---
 rtl/rle_pkg.sv | 9 +
 rtl/rle_coef_bank.sv | 27 ++
 rtl/rle_encoder.sv | 97 +++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// rle_pkg: shared constants, FSM state type and token field widths for the run-length encoder.
package rle_pkg;
  localparam int NUM_COEF = 8;
  localparam int COEF_W = 19;
  localparam int RUN_W = 4;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
endpackage

// File: rtl/rle_coef_bank.sv
// rle_coef_bank: parallel-load coefficient bank with indexed read and thresholded zero detect.
module rle_coef_bank
  import rle_pkg::*;
#(
  parameter int THRESH = 0,
  parameter int COEF_W = rle_pkg::COEF_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic signed [COEF_W-1:0] din [NUM_COEF],
  input  logic [IDX_W-1:0]         idx,
  output logic signed [COEF_W-1:0] coef,
  output logic                     is_zero
);
  localparam logic signed [COEF_W:0] TH = (COEF_W + 1)'(THRESH);
  logic signed [COEF_W-1:0] bank [NUM_COEF];
  logic signed [COEF_W:0] ext, mag;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bank <= '{default: '0};
    else if (load) bank <= din;
  assign coef = bank[idx];
  // one extra bit so the most-negative coefficient has a representable magnitude
  assign ext = {coef[COEF_W-1], coef};
  assign mag = ext[COEF_W] ? -ext : ext;
  assign is_zero = (coef == '0) || (mag < TH);
endmodule

// File: rtl/rle_encoder.sv
// rle_encoder: captures an 8-coefficient DCT block and serialises it into (run, value, last) tokens.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int THRESH = 0,
  parameter int COEF_W = rle_pkg::COEF_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] z0,
  input  logic signed [COEF_W-1:0] z1,
  input  logic signed [COEF_W-1:0] z2,
  input  logic signed [COEF_W-1:0] z3,
  input  logic signed [COEF_W-1:0] z4,
  input  logic signed [COEF_W-1:0] z5,
  input  logic signed [COEF_W-1:0] z6,
  input  logic signed [COEF_W-1:0] z7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RUN_W-1:0]         out_run,
  output logic signed [COEF_W-1:0] out_value,
  output logic                     out_last
);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [RUN_W-1:0] cnt, cnt_n, run_n;
  logic signed [COEF_W-1:0] val_n, coef;
  logic signed [COEF_W-1:0] zv [NUM_COEF];
  logic valid_n, last_n, is_zero;
  assign zv = '{z0, z1, z2, z3, z4, z5, z6, z7};
  assign in_ready = (state == IDLE) && en;
  rle_coef_bank #(.THRESH(THRESH), .COEF_W(COEF_W)) u_bank (
    .clk(clk),
    .rst_n(rst_n),
    .load(in_valid && in_ready),
    .din(zv),
    .idx(idx),
    .coef(coef),
    .is_zero(is_zero)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    valid_n = out_valid;
    run_n = out_run;
    val_n = out_value;
    last_n = out_last;
    if (en)
      case (state)
        IDLE: if (in_valid) begin
          state_n = SCAN;
          idx_n = '0;
          cnt_n = '0;
        end
        SCAN: if (is_zero && idx != LAST_IDX) begin
          cnt_n = cnt + 4'd1;
          idx_n = idx + 3'd1;
        end else begin
          // a trailing zero closes the block as an end-of-block token
          state_n = EMIT;
          valid_n = 1'b1;
          run_n = is_zero ? cnt + 4'd1 : cnt;
          val_n = is_zero ? '0 : coef;
          last_n = (idx == LAST_IDX);
          cnt_n = '0;
        end
        EMIT: if (out_ready) begin
          valid_n = 1'b0;
          state_n = out_last ? IDLE : SCAN;
          idx_n = idx + 3'd1;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_run <= '0;
      out_value <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      out_valid <= valid_n;
      out_run <= run_n;
      out_value <= val_n;
      out_last <= last_n;
    end
endmodule
